// File: rtl/vga_pkg.sv
// Shared screen geometry and colour constants for the VGA pixel pipeline.
package vga_pkg;

  // Visible area and total scan size of the 640x480@60 timing.
  localparam int HD   = 640;
  localparam int VD   = 480;
  localparam int HMAX = 800;
  localparam int VMAX = 525;

  // 12-bit colours packed as {R[3:0],G[3:0],B[3:0]}.
  localparam logic [11:0] BG_COLOR   = 12'h000;
  localparam logic [11:0] WALL_COLOR = 12'hFFF;

  // Box colour cycle: red, green, blue, yellow.
  localparam logic [11:0] PALETTE [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};

  // Look up the box colour for a palette index.
  function automatic logic [11:0] palette_color(input logic [1:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position register, travel direction and
// edge detection. Moves SPEED pixels per step and clamps at 0 and LIMIT.
module vga_bounce_axis #(
  parameter int LIMIT = 608,
  parameter int SPEED = 2,
  parameter int START = 304
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       step,
  output logic [9:0] pos,
  output logic       dir,
  output logic       bounce
);

  // 11-bit working width so pos+SPEED can never wrap.
  localparam logic [10:0] LIMIT_W = 11'(LIMIT);
  localparam logic [10:0] SPEED_W = 11'(SPEED);

  logic [10:0] pos_ext;
  logic        hit_high;
  logic        hit_low;

  assign pos_ext  = {1'b0, pos};
  assign hit_high = (pos_ext + SPEED_W) >= LIMIT_W;
  assign hit_low  = pos_ext <= SPEED_W;

  // A bounce is reported in the same cycle the clamping step is taken.
  assign bounce = step && (dir ? hit_high : hit_low);

  // Position/direction update, once per accepted step.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      pos <= 10'(START);
      dir <= 1'b1;
    end else if (step) begin
      if (dir) begin
        if (hit_high) begin
          pos <= 10'(LIMIT);
          dir <= 1'b0;
        end else begin
          pos <= pos + 10'(SPEED);
        end
      end else begin
        if (hit_low) begin
          pos <= 10'd0;
          dir <= 1'b1;
        end else begin
          pos <= pos - 10'(SPEED);
        end
      end
    end
  end

endmodule

// File: rtl/vga_bounce_box.sv
// Pixel generator behind the VGA timing controller: white 1-pixel border
// plus a bouncing square that changes colour on every bounce. RGB and the
// syncs are registered together on the pixel enable so they stay aligned.
module vga_bounce_box #(
  parameter int HD      = vga_pkg::HD,
  parameter int VD      = vga_pkg::VD,
  parameter int SIZE    = 32,
  parameter int SPEED   = 2,
  parameter int START_X = 304,
  parameter int START_Y = 224
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick
);

  import vga_pkg::*;

  localparam logic [10:0] SIZE_W   = 11'(SIZE);
  localparam logic [9:0]  X_LAST   = 10'(HD - 1);
  localparam logic [9:0]  Y_LAST   = 10'(VD - 1);
  localparam logic [9:0]  Y_BLANK  = 10'(VD);

  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic        dir_x;
  logic        dir_y;
  logic        bounce_x;
  logic        bounce_y;
  logic        step;
  logic [1:0]  color_idx;

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic [10:0] box_x_ext;
  logic [10:0] box_y_ext;
  logic        in_box_p0;
  logic        on_wall_p0;
  logic [11:0] color_p0;

  // Motion only advances on the frame boundary, so the box is stable while
  // the visible area is being scanned.
  assign step = frame_tick && !pause;

  vga_bounce_axis #(
    .LIMIT (HD - SIZE),
    .SPEED (SPEED),
    .START (START_X)
  ) u_axis_x (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .step       (step),
    .pos        (box_x),
    .dir        (dir_x),
    .bounce     (bounce_x)
  );

  vga_bounce_axis #(
    .LIMIT (VD - SIZE),
    .SPEED (SPEED),
    .START (START_Y)
  ) u_axis_y (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .step       (step),
    .pos        (box_y),
    .dir        (dir_y),
    .bounce     (bounce_y)
  );

  // Stage p0: classify the current pixel; box wins over the border.
  always_comb begin
    x_ext      = {1'b0, x};
    y_ext      = {1'b0, y};
    box_x_ext  = {1'b0, box_x};
    box_y_ext  = {1'b0, box_y};
    in_box_p0  = (x_ext >= box_x_ext) && (x_ext < box_x_ext + SIZE_W) &&
                 (y_ext >= box_y_ext) && (y_ext < box_y_ext + SIZE_W);
    on_wall_p0 = (x == 10'd0) || (x == X_LAST) || (y == 10'd0) || (y == Y_LAST);
    color_p0   = BG_COLOR;
    if (!video_on) begin
      color_p0 = 12'h000;
    end else if (in_box_p0) begin
      color_p0 = palette_color(color_idx);
    end else if (on_wall_p0) begin
      color_p0 = WALL_COLOR;
    end
  end

  // Stage p1: register colour and syncs together on the pixel enable.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (p_tick) begin
      rgb       <= color_p0;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

  // One-clock pulse at the first pixel of vertical blanking.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= p_tick && (x == 10'd0) && (y == Y_BLANK);
    end
  end

  // Advance the colour once per bouncing frame, even on a corner hit.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      color_idx <= 2'd0;
    end else if (bounce_x || bounce_y) begin
      color_idx <= color_idx + 2'd1;
    end
  end

endmodule
